// File: rtl/mul_pkg.sv
// Shared definitions for the RV32M multiply issue pipeline.
// Holds the funct3 encodings and the operand-sign encodings. It also holds the
// stage payload structs and the funct3 -> {x_sign,y_sign} decode.
package mul_pkg;

  localparam int XLEN_C  = 32;
  localparam int TAG_W_C = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  // {x_sign, y_sign} operand interpretation
  localparam logic [1:0] MUL_OP_MULH   = 2'b11;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b00;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHUS = 2'b01;

  typedef struct packed {
    logic [XLEN_C-1:0]  rs1;
    logic [XLEN_C-1:0]  rs2;
    logic               x_sign;
    logic               y_sign;
    logic               hi_sel;
    logic               illegal;
    logic [TAG_W_C-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [2*XLEN_C-1:0] prod;
    logic                hi_sel;
    logic                illegal;
    logic [TAG_W_C-1:0]  tag;
  } s2_t;

  // MUL only keeps the low word, so it can use the signed encoding.
  // Unknown funct3 values multiply unsigned and are flagged illegal elsewhere.
  function automatic logic [1:0] decode_signs(input logic [2:0] f3);
    logic [1:0] s;
    s = MUL_OP_MULHU;
    case (f3)
      F3_MUL, F3_MULH: s = MUL_OP_MULH;
      F3_MULHSU:       s = MUL_OP_MULHSU;
      F3_MULHU:        s = MUL_OP_MULHU;
      default:         s = MUL_OP_MULHU;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mult_booth.sv
// Combinational W x W multiplier that returns the full 2W-bit product.
// x_sign / y_sign select two's-complement or unsigned interpretation per operand.
// Ports: x, y (operands), x_sign, y_sign (signedness), prod (2W-bit product).
module mult_booth #(
  parameter int W = 32
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           x_sign,
  input  logic           y_sign,
  output logic [2*W-1:0] prod
);

  logic signed [2*W-1:0] x_ext;
  logic signed [2*W-1:0] y_ext;

  // Extending both operands to 2W bits makes a 2W-bit product exact modulo 2^(2W).
  // That covers every signedness mix.
  assign x_ext = {{W{x_sign & x[W-1]}}, x};
  assign y_ext = {{W{y_sign & y[W-1]}}, y};
  assign prod  = x_ext * y_ext;

endmodule

// File: rtl/mul_issue_pipe.sv
// Two-stage pipelined RV32M multiply unit between EX issue and the MEM/WB mux.
// Stage 1 registers operands plus decoded sign flags. Stage 2 registers the
// 64-bit product. The response word is selected combinationally from stage 2.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush_i                    kill every in-flight op (and a same-cycle request)
//   req_valid_i/req_ready_o    request handshake
//   req_funct3_i               RV32M funct3 (MUL/MULH/MULHSU/MULHU)
//   req_rs1_i, req_rs2_i       multiplicand / multiplier
//   req_tag_i                  destination register tag
//   rsp_valid_o/rsp_ready_i    response handshake
//   rsp_data_o, rsp_tag_o      result word and its tag
//   rsp_illegal_o              funct3[2] was set; data forced to zero
//   busy_o                     any stage holds a valid op
// Only XLEN=32 and TAG_W=5 (the package widths) are supported.
module mul_issue_pipe
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_funct3_i,
  input  logic [XLEN-1:0]  req_rs1_i,
  input  logic [XLEN-1:0]  req_rs2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [XLEN-1:0]  rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_illegal_o,
  output logic             busy_o
);

  s1_t               stg_p1;
  s1_t               nxt_p1;
  s2_t               stg_p2;
  logic              vld_p1;
  logic              vld_p2;
  logic [2*XLEN-1:0] prod_p1;
  logic              s1_adv;
  logic              s2_adv;
  logic              fire;

  function automatic logic [XLEN-1:0] sel_word(input s2_t s);
    logic [XLEN-1:0] w;
    if (s.illegal)     w = '0;
    else if (s.hi_sel) w = s.prod[2*XLEN-1:XLEN];
    else               w = s.prod[XLEN-1:0];
    return w;
  endfunction

  // A stage may take new data when it is empty or its occupant moves on this cycle.
  assign s2_adv      = !vld_p2 || rsp_ready_i;
  assign s1_adv      = !vld_p1 || s2_adv;
  assign req_ready_o = s1_adv;
  assign fire        = req_valid_i && s1_adv;

  always_comb begin
    nxt_p1                   = '0;
    nxt_p1.rs1               = req_rs1_i;
    nxt_p1.rs2               = req_rs2_i;
    {nxt_p1.x_sign, nxt_p1.y_sign} = decode_signs(req_funct3_i);
    nxt_p1.illegal           = req_funct3_i[2];
    nxt_p1.hi_sel            = !req_funct3_i[2] && (req_funct3_i[1:0] != 2'b00);
    nxt_p1.tag               = req_tag_i;
  end

  // ---- stage 0 -> stage 1: operand capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      stg_p1 <= '0;
    end else begin
      if (flush_i)     vld_p1 <= 1'b0;
      else if (s1_adv) vld_p1 <= req_valid_i;
      if (fire)        stg_p1 <= nxt_p1;
    end
  end

  mult_booth #(.W(XLEN)) u_mult (
    .x      (stg_p1.rs1),
    .y      (stg_p1.rs2),
    .x_sign (stg_p1.x_sign),
    .y_sign (stg_p1.y_sign),
    .prod   (prod_p1)
  );

  // ---- stage 1 -> stage 2: product capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      stg_p2 <= '0;
    end else begin
      if (flush_i)     vld_p2 <= 1'b0;
      else if (s2_adv) vld_p2 <= vld_p1;
      if (s2_adv && vld_p1) begin
        stg_p2.prod    <= prod_p1;
        stg_p2.hi_sel  <= stg_p1.hi_sel;
        stg_p2.illegal <= stg_p1.illegal;
        stg_p2.tag     <= stg_p1.tag;
      end
    end
  end

  // ---- stage 2 -> response ----
  assign rsp_valid_o   = vld_p2;
  assign rsp_data_o    = sel_word(stg_p2);
  assign rsp_tag_o     = stg_p2.tag;
  assign rsp_illegal_o = stg_p2.illegal;
  assign busy_o        = vld_p1 || vld_p2;

endmodule

// File: tb/tb_mul_issue_pipe.sv
// Self-checking bench for mul_issue_pipe.
// The reference model treats the unit as an elastic queue of at most two ops.
// The oldest op becomes visible one edge after capture. A new op is accepted
// unless two ops are held and the consumer stalls.
module tb_mul_issue_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i = 3'b000;
  logic [31:0] req_rs1_i = '0;
  logic [31:0] req_rs2_i = '0;
  logic [4:0]  req_tag_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_tag_o;
  logic        rsp_illegal_o;
  logic        busy_o;

  mul_issue_pipe dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_funct3_i  (req_funct3_i),
    .req_rs1_i     (req_rs1_i),
    .req_rs2_i     (req_rs2_i),
    .req_tag_i     (req_tag_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_data_o    (rsp_data_o),
    .rsp_tag_o     (rsp_tag_o),
    .rsp_illegal_o (rsp_illegal_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
    logic        ill;
    int          age;
  } m_t;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
  } rec_t;

  m_t   q[$];
  m_t   m_new;
  rec_t log_q[$];
  rec_t r;

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] xa;
    logic [63:0] yb;
    logic [63:0] p;
    xa = ((f3 == 3'b001 || f3 == 3'b010) && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    yb = ((f3 == 3'b001) && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    p  = xa * yb;
    if (f3[2])         return 32'h0;
    if (f3 == 3'b000)  return p[31:0];
    return p[63:32];
  endfunction

  function automatic bit m_vis();
    return (q.size() > 0) && (q[0].age >= 1);
  endfunction

  function automatic bit m_rdy();
    return (q.size() < 2) || rsp_ready_i;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      bit vis;
      bit rdy;
      vis = m_vis();
      rdy = m_rdy();
      if (flush_i) begin
        q.delete();
      end else begin
        if (vis && rsp_ready_i) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (req_valid_i && rdy) begin
          m_new.tag  = req_tag_i;
          m_new.data = ref_result(req_funct3_i, req_rs1_i, req_rs2_i);
          m_new.ill  = req_funct3_i[2];
          m_new.age  = 0;
          q.push_back(m_new);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("mdl_rsp_valid", {31'b0, rsp_valid_o}, {31'b0, m_vis()});
      chk("mdl_req_ready", {31'b0, req_ready_o}, {31'b0, m_rdy()});
      chk("mdl_busy", {31'b0, busy_o}, {31'b0, q.size() > 0});
      if (m_vis()) begin
        chk("mdl_data", rsp_data_o, q[0].data);
        chk("mdl_tag", {27'b0, rsp_tag_o}, {27'b0, q[0].tag});
        chk("mdl_illegal", {31'b0, rsp_illegal_o}, {31'b0, q[0].ill});
      end
      if (rst_n && rsp_valid_o && rsp_ready_i && !flush_i) begin
        r.tag  = rsp_tag_o;
        r.data = rsp_data_o;
        log_q.push_back(r);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    int n;
    req_funct3_i = f3;
    req_rs1_i    = a;
    req_rs2_i    = b;
    req_tag_i    = t;
    req_valid_i  = 1'b1;
    #1;
    n = 0;
    while (!req_ready_o && n < 20) begin
      step();
      #1;
      n++;
    end
    if (!req_ready_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: req_ready stayed 0 for tag %0d", t);
    end
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic run_single(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] t, input logic [31:0] expd, input logic expill);
    issue(f3, a, b, t);
    #1;
    chk("lat_not_early", {31'b0, rsp_valid_o}, 32'h0);
    step();
    #1;
    chk("lat_valid", {31'b0, rsp_valid_o}, 32'h1);
    chk("single_data", rsp_data_o, expd);
    chk("single_tag", {27'b0, rsp_tag_o}, {27'b0, t});
    chk("single_illegal", {31'b0, rsp_illegal_o}, {31'b0, expill});
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  mark;
    bit  dropped;
    logic [31:0] held;

    #1 rst_n = 1'b0;
    repeat (3) step();
    #1;
    chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_data", rsp_data_o, 32'h0);
    chk("rst_tag", {27'b0, rsp_tag_o}, 32'h0);
    chk("rst_illegal", {31'b0, rsp_illegal_o}, 32'h0);
    chk("rst_ready", {31'b0, req_ready_o}, 32'h1);
    step();
    rst_n       = 1'b1;
    rsp_ready_i = 1'b1;
    step();

    run_single(3'b001, 32'hFFFF_FFF8, 32'h0000_0001, 5'd3, 32'hFFFF_FFFF, 1'b0);
    run_single(3'b011, 32'hFFFF_FFF8, 32'h0000_0001, 5'd3, 32'h0000_0000, 1'b0);
    run_single(3'b010, 32'hFFFF_FFF8, 32'h0000_0001, 5'd3, 32'hFFFF_FFFF, 1'b0);
    run_single(3'b000, 32'hFFFF_FFF8, 32'h0000_0001, 5'd3, 32'hFFFF_FFF8, 1'b0);
    run_single(3'b010, 32'h0000_0002, 32'hFFFF_FFFF, 5'd9, 32'h0000_0001, 1'b0);
    run_single(3'b100, 32'h0000_1234, 32'h0000_5678, 5'd7, 32'h0000_0000, 1'b1);

    // back-to-back stream
    mark    = log_q.size();
    dropped = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_funct3_i = 3'b000;
      req_rs1_i    = i + 1;
      req_rs2_i    = 32'd7;
      req_tag_i    = 5'(8 + i);
      req_valid_i  = 1'b1;
      #1;
      if (!req_ready_o) dropped = 1'b1;
      step();
    end
    req_valid_i = 1'b0;
    chk("stream_ready_held", {31'b0, dropped}, 32'h0);
    repeat (3) step();
    chk("stream_count", log_q.size() - mark, 32'd8);
    if (log_q.size() - mark == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("stream_data", log_q[mark+i].data, 7 * (i + 1));
        chk("stream_tag", {27'b0, log_q[mark+i].tag}, 8 + i);
      end
    end

    // backpressure
    rsp_ready_i = 1'b0;
    mark = log_q.size();
    issue(3'b000, 32'd3, 32'd5, 5'd1);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    req_funct3_i = 3'b001;
    req_rs1_i    = 32'h8000_0000;
    req_rs2_i    = 32'h8000_0000;
    req_tag_i    = 5'd4;
    req_valid_i  = 1'b1;
    #1;
    chk("bp_ready_low", {31'b0, req_ready_o}, 32'h0);
    chk("bp_head_data", rsp_data_o, 32'd15);
    held = rsp_data_o;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("bp_ready_low_hold", {31'b0, req_ready_o}, 32'h0);
      chk("bp_data_stable", rsp_data_o, held);
    end
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_ready_release", {31'b0, req_ready_o}, 32'h1);
    step();
    req_valid_i = 1'b0;
    repeat (4) step();
    chk("bp_count", log_q.size() - mark, 32'd3);
    if (log_q.size() - mark == 3) begin
      chk("bp_r0_data", log_q[mark].data, 32'd15);
      chk("bp_r0_tag", {27'b0, log_q[mark].tag}, 32'd1);
      chk("bp_r1_data", log_q[mark+1].data, 32'hFFFF_FFFE);
      chk("bp_r1_tag", {27'b0, log_q[mark+1].tag}, 32'd2);
      chk("bp_r2_data", log_q[mark+2].data, 32'h4000_0000);
      chk("bp_r2_tag", {27'b0, log_q[mark+2].tag}, 32'd4);
    end

    // flush with a third request firing in the flush cycle
    mark = log_q.size();
    issue(3'b000, 32'd2, 32'd3, 5'd10);
    issue(3'b000, 32'd4, 32'd5, 5'd11);
    flush_i      = 1'b1;
    req_funct3_i = 3'b000;
    req_rs1_i    = 32'd6;
    req_rs2_i    = 32'd7;
    req_tag_i    = 5'd12;
    req_valid_i  = 1'b1;
    step();
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    #1;
    chk("flush_busy", {31'b0, busy_o}, 32'h0);
    chk("flush_valid", {31'b0, rsp_valid_o}, 32'h0);
    repeat (3) step();
    chk("flush_no_rsp", log_q.size() - mark, 32'd0);

    // asynchronous reset in the middle of a stall
    rsp_ready_i = 1'b0;
    issue(3'b000, 32'd9, 32'd9, 5'd20);
    issue(3'b000, 32'd8, 32'd8, 5'd21);
    #1;
    chk("stall_busy", {31'b0, busy_o}, 32'h1);
    chk("stall_valid", {31'b0, rsp_valid_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, rsp_valid_o}, 32'h0);
    chk("arst_busy", {31'b0, busy_o}, 32'h0);
    chk("arst_ready", {31'b0, req_ready_o}, 32'h1);
    chk("arst_data", rsp_data_o, 32'h0);
    repeat (2) step();
    rst_n       = 1'b1;
    rsp_ready_i = 1'b1;
    mark = log_q.size();
    repeat (4) step();
    chk("arst_no_rsp", log_q.size() - mark, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
